// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall/flush controller:
//   - FSM state encoding (RUN, LU_STALL)
//   - pipeline register indices (PC_IDX .. MEMWB)
//   - prefix_mask(): builds a contiguous stall mask covering bits [idx:0]
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // FSM state encoding
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] LU_STALL = 1'b1;

    // Pipeline register indices as used by stall_o (bit k = register after stage k)
    localparam int unsigned PC_IDX = 0;
    localparam int unsigned IFID   = 1;
    localparam int unsigned IDEX   = 2;
    localparam int unsigned EXMEM  = 3;
    localparam int unsigned MEMWB  = 4;

    // Stalling register k requires every upstream register to hold too,
    // so a stall pattern is always a prefix of ones ending at idx.
    function automatic logic [31:0] prefix_mask(input int unsigned idx);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i <= idx) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard comparator.
// Ports:
//   id_rs_i / id_rt_i        ID-stage source specifiers
//   id_rs_rd_i / id_rt_rd_i  source actually read by the ID instruction
//   ex_mem_read_i            EX-stage instruction is a load
//   ex_rd_i                  EX-stage destination
//   hazard_o                 ID consumes the value the EX load produces
// -----------------------------------------------------------------------------
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_rs_rd_i,
    input  logic                  id_rt_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    output logic                  hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_rs_rd_i & (id_rs_i == ex_rd_i);
    assign rt_match = id_rt_rd_i & (id_rt_i == ex_rd_i);
    assign hazard_o = ex_mem_read_i & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline control unit: owns every stall and flush decision of the in-order
// core (data-memory wait, branch/jump redirect, load-use bubble, fetch wait).
// A redirect arriving during a data-memory wait is held pending and applied in
// the first cycle the wait ends.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   id_rs_i, id_rt_i      ID-stage sources; id_rs_rd_i/id_rt_rd_i mark real reads
//   ex_mem_read_i, ex_rd_i EX-stage load flag and destination
//   redirect_i            taken branch/jump resolved in EX (pulse)
//   inst_ready_i          fetch data valid
//   mem_req_i, mem_ready_i data access request / completion
//   stall_o               hold enables, bit0=PC, bit k=register after stage k
//   flush_o               bubble inserts, bit k-1=register after stage k
//   redirect_o            PC-load strobe
//   stall_cnt_o           cycles with any stall bit set (saturating)
//   flush_cnt_o           redirects applied (saturating)
//
// Configuration: define PIPE_PERF_CNT_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned LOAD_USE_CYC = 1,
    parameter int unsigned MEM_STAGE    = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_rs_rd_i,
    input  logic                  id_rt_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  redirect_i,
    input  logic                  inst_ready_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    output logic [NUM_STAGES:0]   stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  redirect_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [31:0] MEM_MASK   = prefix_mask(MEM_STAGE);
    localparam logic [31:0] LU_MASK    = prefix_mask(IFID);
    localparam logic [31:0] FETCH_MASK = prefix_mask(PC_IDX);
    localparam logic [2:0]  LU_LOAD    = 3'(LOAD_USE_CYC - 1);
    localparam bit          LU_MULTI   = (LOAD_USE_CYC > 1);

    logic [0:0] state_q, state_d;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic       pend_q, pend_d;

    logic hazard;
    logic mem_wait;
    logic redir_req;
    logic lu_active;

    logic [NUM_STAGES:0]   stall_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic                  redir_c;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_detect (
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rs_rd_i    (id_rs_rd_i),
        .id_rt_rd_i    (id_rt_rd_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .hazard_o      (hazard)
    );

    assign mem_wait  = mem_req_i & ~mem_ready_i;
    assign redir_req = redirect_i | pend_q;
    // In LU_STALL the countdown alone holds the bubble; fresh hazards are moot.
    assign lu_active = hazard | (state_q == LU_STALL);

    // Output decode: highest-priority event wins outright.
    always_comb begin
        stall_c = '0;
        flush_c = '0;
        redir_c = 1'b0;
        if (!rst_n_i) begin
            // outputs held quiet while reset is asserted
        end else if (mem_wait) begin
            stall_c            = MEM_MASK[NUM_STAGES:0];
            flush_c[MEM_STAGE] = 1'b1;
        end else if (redir_req) begin
            redir_c            = 1'b1;
            flush_c[IFID-1]    = 1'b1;
            flush_c[IDEX-1]    = 1'b1;
        end else if (lu_active) begin
            stall_c            = LU_MASK[NUM_STAGES:0];
            flush_c[IDEX-1]    = 1'b1;
        end else if (!inst_ready_i) begin
            stall_c            = FETCH_MASK[NUM_STAGES:0];
            flush_c[IFID-1]    = 1'b1;
        end
    end

    // Next-state: a memory wait freezes the FSM and only records a redirect.
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        pend_d   = pend_q;
        if (mem_wait) begin
            if (redirect_i) pend_d = 1'b1;
        end else if (redir_req) begin
            pend_d   = 1'b0;
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (state_q == LU_STALL) begin
            if (lu_cnt_q <= 3'd1) begin
                state_d  = RUN;
                lu_cnt_d = '0;
            end else begin
                lu_cnt_d = lu_cnt_q - 3'd1;
            end
        end else if (hazard && LU_MULTI) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_LOAD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            pend_q   <= pend_d;
        end
    end

    assign stall_o    = stall_c;
    assign flush_o    = flush_c;
    assign redirect_o = redir_c;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((|stall_c) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (redir_c && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two controller instances share the stimulus: A with single-cycle load-use
// bubbles and wide counters, B with three-cycle bubbles and 4-bit counters so
// saturation is reached. Both are compared every cycle against a behavioural
// model driven by the controller's event rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_rs_rd, id_rt_rd, ex_mem_read;
    logic       redirect, inst_ready, mem_req, mem_ready;

    logic [5:0]  stall_a, stall_b;
    logic [4:0]  flush_a, flush_b;
    logic        redir_a, redir_b;
    logic [31:0] scnt_a, fcnt_a;
    logic [3:0]  scnt_b, fcnt_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(3), .LOAD_USE_CYC(1),
                       .MEM_STAGE(3), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_rd_i(id_rs_rd), .id_rt_rd_i(id_rt_rd),
        .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd), .redirect_i(redirect),
        .inst_ready_i(inst_ready), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .stall_o(stall_a), .flush_o(flush_a), .redirect_o(redir_a),
        .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
    );

    pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(3), .LOAD_USE_CYC(3),
                       .MEM_STAGE(3), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_rd_i(id_rs_rd), .id_rt_rd_i(id_rt_rd),
        .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd), .redirect_i(redirect),
        .inst_ready_i(inst_ready), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .stall_o(stall_b), .flush_o(flush_b), .redirect_o(redir_b),
        .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                lu_left [2];   // remaining forced bubbles after this one
    bit                pend    [2];
    longint unsigned   scnt    [2];
    longint unsigned   fcnt    [2];
    int                luc     [2] = '{1, 3};
    int                cw      [2] = '{32, 4};

    function automatic bit hazard_now();
        return ex_mem_read && ((id_rs_rd && id_rs == ex_rd) || (id_rt_rd && id_rt == ex_rd));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            lu_left[i] = 0; pend[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        end
    endtask

    task automatic model_out(input int i, output logic [5:0] st, output logic [4:0] fl,
                             output logic ro);
        st = 6'h00; fl = 5'h00; ro = 1'b0;
        if (!rst_n) return;
        if (mem_req && !mem_ready) begin
            st = 6'h0F; fl = 5'h08;        // PC..EX/MEM held, MEM/WB gets bubble
        end else if (redirect || pend[i]) begin
            ro = 1'b1; fl = 5'h03;
        end else if (lu_left[i] > 0 || hazard_now()) begin
            st = 6'h03; fl = 5'h02;
        end else if (!inst_ready) begin
            st = 6'h01; fl = 5'h01;
        end
    endtask

    task automatic model_tick();
        logic [5:0] st; logic [4:0] fl; logic ro;
        longint unsigned mx;
        for (int i = 0; i < 2; i++) begin
            model_out(i, st, fl, ro);
            mx = (64'd1 << cw[i]) - 64'd1;
            if (st != 0 && scnt[i] < mx) scnt[i]++;
            if (ro && fcnt[i] < mx) fcnt[i]++;
            if (mem_req && !mem_ready) begin
                if (redirect) pend[i] = 1;
            end else if (redirect || pend[i]) begin
                pend[i] = 0; lu_left[i] = 0;
            end else if (lu_left[i] > 0) begin
                lu_left[i]--;
            end else if (hazard_now()) begin
                lu_left[i] = luc[i] - 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [5:0] st; logic [4:0] fl; logic ro;
        model_out(0, st, fl, ro);
        check({tag, ":A.stall"}, stall_a, st);
        check({tag, ":A.flush"}, flush_a, fl);
        check({tag, ":A.redir"}, redir_a, ro);
        check({tag, ":A.scnt"}, scnt_a, PERF ? scnt[0] : 64'd0);
        check({tag, ":A.fcnt"}, fcnt_a, PERF ? fcnt[0] : 64'd0);
        model_out(1, st, fl, ro);
        check({tag, ":B.stall"}, stall_b, st);
        check({tag, ":B.flush"}, flush_b, fl);
        check({tag, ":B.redir"}, redir_b, ro);
        check({tag, ":B.scnt"}, scnt_b, PERF ? scnt[1] : 64'd0);
        check({tag, ":B.fcnt"}, fcnt_b, PERF ? fcnt[1] : 64'd0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic step(input string tag);
        #4;
        compare_all(tag);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        #2;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle();
        id_rs = 3'd1; id_rt = 3'd2; ex_rd = 3'd5;
        id_rs_rd = 1'b0; id_rt_rd = 1'b0; ex_mem_read = 1'b0;
        redirect = 1'b0; inst_ready = 1'b1; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic set_hazard();
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_rd = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_clear();
        #3;
        @(posedge clk);
        #1;
        do_reset();

        // clean running
        repeat (3) step("idle");

        // load-use: A bubbles once, B three times
        set_hazard(); step("lu0");
        idle(); repeat (4) step("lu_after");

        // memory wait with redirect in cycle 2, applied when ready
        mem_req = 1'b1; mem_ready = 1'b0; step("mw1");
        redirect = 1'b1; step("mw2");
        redirect = 1'b0; step("mw3");
        redirect = 1'b1; step("mw4");   // second redirect while pending
        redirect = 1'b0; mem_ready = 1'b1; step("mw_done");
        idle(); repeat (2) step("mw_after");

        // redirect during LU_STALL countdown
        set_hazard(); step("lur0");
        idle(); redirect = 1'b1; step("lur1");
        redirect = 1'b0; repeat (2) step("lur2");

        // fetch wait, and redirect priority over load-use and fetch wait
        inst_ready = 1'b0; repeat (2) step("fw");
        set_hazard(); redirect = 1'b1; step("prio_redir");
        redirect = 1'b0; step("prio_lu");
        idle(); repeat (3) step("prio_after");

        // reset in the middle of a wait with a redirect pending
        mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1; step("rw1");
        redirect = 1'b0;
        do_reset();
        mem_ready = 1'b1; step("rw_after");
        idle(); step("rw_idle");

        // counters: 10 stall cycles plus 2 redirects from a fresh reset
        do_reset();
        inst_ready = 1'b0; repeat (10) step("cnt_st");
        idle(); redirect = 1'b1; step("cnt_r1");
        redirect = 1'b0; step("cnt_gap");
        redirect = 1'b1; step("cnt_r2");
        redirect = 1'b0; step("cnt_chk");

        // randomized traffic, occasional resets; B counters saturate
        for (int n = 0; n < 1500; n++) begin
            id_rs       = 3'($urandom_range(0, 7));
            id_rt       = 3'($urandom_range(0, 7));
            ex_rd       = 3'($urandom_range(0, 7));
            id_rs_rd    = ($urandom_range(0, 99) < 70);
            id_rt_rd    = ($urandom_range(0, 99) < 50);
            ex_mem_read = ($urandom_range(0, 99) < 35);
            redirect    = ($urandom_range(0, 99) < 10);
            inst_ready  = ($urandom_range(0, 99) < 80);
            mem_req     = ($urandom_range(0, 99) < 30);
            mem_ready   = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
